boot_loader: RTL and testbench

- Serial program loader that runs ahead of the cpu core.
- Receives a UART 8N1 image, assembles big-endian 32-bit words and writes them into ram port a from address 0.
- Holds the core in reset until the image is complete.
- Top level muxes ram port a (we/addr/wdata) to this block while cpu_reset is high, and to the memory stage otherwise.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/boot_loader_if.sv | 12 +
 rtl/boot_loader_uart_rx.sv | 108 ++++++++++
 rtl/boot_loader.sv | 126 ++++++++++++
 tb/tb_boot_loader.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and state encodings for the serial boot loader.
package cpu_pkg;

  localparam int          RAM_AW  = 9;
  localparam logic [3:0]  WE_WORD = 4'b1111;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
`ifdef BOOT_LOADER_CHECKSUM_EN
    CHECK  = 3'd3,
`endif
    DONE   = 3'd4,
    ERROR  = 3'd5
  } bl_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/boot_loader_if.sv
// RAM port-a write bus plus the cpu hold/status lines driven by the boot loader.
interface boot_loader_if;
  logic [3:0]               ram_we;
  logic [cpu_pkg::RAM_AW-1:0] ram_addr;
  logic [31:0]              ram_wdata;
  logic                     cpu_reset;
  logic                     done;
  logic                     error;

  modport master (output ram_we, ram_addr, ram_wdata, cpu_reset, done, error);
  modport slave  (input  ram_we, ram_addr, ram_wdata, cpu_reset, done, error);
endinterface

// File: rtl/boot_loader_uart_rx.sv
// UART 8N1 receiver: 2-flop synchronizer, mid-bit sampling, 1-cycle byte/frame-error strobes.
module uart_rx
  import cpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state_q, state_d;
  logic [1:0]       sync_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sr_q, sr_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RX_IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx};
      prev_q  <= rx_s;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = HALF_LD;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          // a start bit that is high again at mid-bit was only a glitch
          if (rx_s) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = FULL_LD;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          sr_d  = {rx_s, sr_q[7:1]};
          cnt_d = FULL_LD;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          state_d = RX_IDLE;
          valid_d = rx_s;
          ferr_d  = !rx_s;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign rx_byte    = sr_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/boot_loader.sv
// Serial image loader: writes big-endian words to ram port a and holds the cpu in reset until done.
// Optional trailing XOR checksum byte enabled by BOOT_LOADER_CHECKSUM_EN.
module boot_loader
  import cpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int RAM_WORDS    = 512
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  boot_loader_if.master bus
);

  logic             byte_valid, frame_err;
  logic [7:0]       rx_byte;

  bl_state_t        state_q, state_d;
  logic [15:0]      count_q, count_d;
  logic [31:0]      asm_q, asm_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [RAM_AW-1:0] idx_q, idx_d;
  logic             wr_q, wr_d;
  logic [15:0]      len_w;

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam bl_state_t LOADED = CHECK;
  logic [7:0]       csum_q, csum_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`else
  localparam bl_state_t LOADED = DONE;
`endif

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  assign len_w = {count_q[15:8], rx_byte};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LEN_HI;
      count_q    <= '0;
      asm_q      <= '0;
      byte_cnt_q <= '0;
      idx_q      <= '0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      asm_q      <= asm_d;
      byte_cnt_q <= byte_cnt_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    asm_d      = asm_q;
    byte_cnt_d = byte_cnt_q;
    idx_d      = idx_q;
    wr_d       = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (frame_err && state_q != DONE && state_q != ERROR) begin
      state_d = ERROR;
    end else begin
      case (state_q)
        LEN_HI: begin
          if (byte_valid) begin
            count_d[15:8] = rx_byte;
            state_d       = LEN_LO;
          end
        end
        LEN_LO: begin
          if (byte_valid) begin
            count_d[7:0] = rx_byte;
            if (len_w == 16'd0)                  state_d = LOADED;
            else if (len_w > 16'(RAM_WORDS))     state_d = ERROR;
            else                                 state_d = DATA;
          end
        end
        DATA: begin
          // the last word leaves the index at N-1 so the address never wraps
          if (wr_q) begin
            if (16'(idx_q) == count_q - 16'd1) state_d = LOADED;
            else                               idx_d   = idx_q + 1'b1;
          end else if (byte_valid) begin
            asm_d      = {asm_q[23:0], rx_byte};
            byte_cnt_d = byte_cnt_q + 2'd1;
            wr_d       = (byte_cnt_q == 2'd3);
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_d     = csum_q ^ rx_byte;
`endif
          end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        CHECK: begin
          if (byte_valid) state_d = (rx_byte == csum_q) ? DONE : ERROR;
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  assign bus.ram_we    = (wr_q && state_q == DATA) ? WE_WORD : 4'b0000;
  assign bus.ram_addr  = idx_q;
  assign bus.ram_wdata = asm_q;
  assign bus.cpu_reset = (state_q != DONE);
  assign bus.done      = (state_q == DONE);
  assign bus.error     = (state_q == ERROR);

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed and randomized images against an image-level model.
module tb_boot_loader;

  localparam int CPB       = 4;
  localparam int RAM_WORDS = 512;
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  we;
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;

  boot_loader_if bus();

  boot_loader #(.CLKS_PER_BIT(CPB), .RAM_WORDS(RAM_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         fall_cyc = -1;
  int         we_bad = 0;
  logic       prev_cr = 1'b1;
  wr_t        obs_q[$];
  int         obs_cyc[$];
  wr_t        exp_q[$];
  logic [7:0] img_q[$];
  bit         exp_done, exp_err;

  always @(negedge clk) begin : mon
    wr_t w;
    cyc++;
    if (!reset) begin
      prev_cr = 1'b1;
    end else begin
      if (bus.ram_we != 4'b0000) begin
        w.we = bus.ram_we; w.addr = bus.ram_addr; w.data = bus.ram_wdata;
        obs_q.push_back(w);
        obs_cyc.push_back(cyc);
        if (bus.done || bus.error) we_bad++;
      end
      if (prev_cr && !bus.cpu_reset) fall_cyc = cyc;
      prev_cr = bus.cpu_reset;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2*CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    obs_q.delete(); obs_cyc.delete();
    fall_cyc = -1; we_bad = 0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [7:0] payload_xor();
    logic [7:0] x = 8'h00;
    for (int i = 2; i < img_q.size(); i++) x ^= img_q[i];
    return x;
  endfunction

  // Image-level model: word count, byte budget and checksum rule decide the outcome.
  task automatic build_expect(input int ferr_at);
    int n, total, usable, nw;
    logic [7:0] x;
    wr_t w;
    exp_q.delete(); exp_done = 0; exp_err = 0;
    if (ferr_at == 0 || ferr_at == 1) begin exp_err = 1; return; end
    n = {img_q[0], img_q[1]};
    if (n > RAM_WORDS) begin exp_err = 1; return; end
    total  = 2 + 4*n + (CS ? 1 : 0);
    usable = (ferr_at >= 0 && ferr_at < total) ? ferr_at : total;
    nw     = (usable - 2) / 4;
    if (nw > n) nw = n;
    for (int k = 0; k < nw; k++) begin
      w.we = 4'hF; w.addr = 9'(k);
      w.data = {img_q[2+4*k], img_q[3+4*k], img_q[4+4*k], img_q[5+4*k]};
      exp_q.push_back(w);
    end
    if (usable < total) exp_err = 1;
    else if (CS) begin
      x = 8'h00;
      for (int i = 2; i < total-1; i++) x ^= img_q[i];
      if (x == img_q[total-1]) exp_done = 1; else exp_err = 1;
    end else exp_done = 1;
  endtask

  task automatic run_image(input int ferr_at, input string name);
    int exp_fall;
    do_reset();
    for (int i = 0; i < img_q.size(); i++) send_byte(img_q[i], i == ferr_at);
    repeat (20) @(negedge clk);
    build_expect(ferr_at);
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL %s write_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s write%0d: got we=%h addr=%0d data=%h expected we=%h addr=%0d data=%h",
                 name, i, obs_q[i].we, obs_q[i].addr, obs_q[i].data,
                 exp_q[i].we, exp_q[i].addr, exp_q[i].data);
      end
    end
    if (obs_q.size() !== exp_q.size()) errors++;
    checks++;
    if (bus.done !== exp_done) begin
      errors++; $display("FAIL %s done: got %b expected %b", name, bus.done, exp_done);
    end
    checks++;
    if (bus.error !== exp_err) begin
      errors++; $display("FAIL %s error: got %b expected %b", name, bus.error, exp_err);
    end
    checks++;
    if (bus.cpu_reset !== !exp_done) begin
      errors++; $display("FAIL %s cpu_reset: got %b expected %b", name, bus.cpu_reset, !exp_done);
    end
    checks++;
    if (we_bad !== 0) begin
      errors++; $display("FAIL %s we_in_terminal: got %0d expected 0", name, we_bad);
    end
`ifndef BOOT_LOADER_CHECKSUM_EN
    if (exp_done && exp_q.size() > 0) begin
      exp_fall = (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size()-1] + 1 : -2;
      checks++;
      if (fall_cyc !== exp_fall) begin
        errors++; $display("FAIL %s cpu_reset_fall: got cycle %0d expected %0d", name, fall_cyc, exp_fall);
      end
    end
`endif
  endtask

  task automatic test_reset();
    bit bad = 0;
    reset = 1'b0;
    repeat (60) begin
      rx = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.ram_we !== 4'h0 || bus.ram_addr !== 9'h0 || bus.ram_wdata !== 32'h0 ||
          bus.cpu_reset !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL reset_hold: got outputs away from reset values, expected we=0 cpu_reset=1 done=0 error=0");
    end
    rx = 1'b1; reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.ram_we !== 4'h0 || bus.cpu_reset !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
      errors++; $display("FAIL reset_release: got we=%h cpu_reset=%b done=%b error=%b expected 0 1 0 0",
                         bus.ram_we, bus.cpu_reset, bus.done, bus.error);
    end
  endtask

  task automatic test_two_word();
    img_q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    if (CS) img_q.push_back(payload_xor());
    run_image(-1, "two_word");
    checks++;
    if (obs_q.size() != 2 || obs_q[0].data !== 32'hDEADBEEF || obs_q[1].data !== 32'h01234567) begin
      errors++; $display("FAIL two_word_data: got %0d writes, expected DEADBEEF then 01234567", obs_q.size());
    end
  endtask

  task automatic test_zero_len();
    img_q = '{8'h00, 8'h00};
    if (CS) img_q.push_back(8'h00);
    img_q.push_back(8'h55); img_q.push_back(8'hAA);
    run_image(-1, "zero_len");
  endtask

  task automatic test_oversize();
    img_q = '{8'h02, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    run_image(-1, "oversize_513");
  endtask

  task automatic test_frame_err();
    img_q = '{8'h00, 8'h01, 8'hAA};
    run_image(2, "frame_err");
    img_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    if (CS) img_q.push_back(payload_xor());
    run_image(-1, "reload");
  endtask

  task automatic test_mid_reset();
    logic [7:0] pre [5] = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(pre[i], 1'b0);
    rx = 1'b0;
    repeat (CPB*5) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.ram_we !== 4'h0 || bus.ram_addr !== 9'h0 || bus.ram_wdata !== 32'h0 ||
        bus.cpu_reset !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs: got we=%h addr=%0d wdata=%h cpu_reset=%b expected all reset values",
                         bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.cpu_reset);
    end
    repeat (CPB*4) @(negedge clk);
    rx = 1'b1; reset = 1'b1;
    repeat (CPB*12) @(negedge clk);
    checks++;
    if (obs_q.size() !== 0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_no_write: got %0d writes done=%b expected 0 writes done=0", obs_q.size(), bus.done);
    end
  endtask

  task automatic test_random();
    int n, ferr;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 5);
      img_q.delete();
      img_q.push_back(8'(n >> 8)); img_q.push_back(8'(n));
      for (int i = 0; i < 4*n; i++) img_q.push_back(8'($urandom));
      if (CS) img_q.push_back(payload_xor() ^ (($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00));
      if (!CS && $urandom_range(0, 1) == 1) img_q.push_back(8'($urandom));
      ferr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, img_q.size()-1)) : -1;
      run_image(ferr, $sformatf("random%0d", it));
    end
    n = $urandom_range(RAM_WORDS+1, 65535);
    img_q.delete();
    img_q.push_back(8'(n >> 8)); img_q.push_back(8'(n));
    img_q.push_back(8'($urandom));
    run_image(-1, "random_oversize");
  endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    img_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run_image(-1, "csum_good");
    img_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    run_image(-1, "csum_bad");
  endtask
`endif

  initial begin
    test_reset();
    test_two_word();
    test_zero_len();
    test_oversize();
    test_frame_err();
    test_mid_reset();
`ifdef BOOT_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
